ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port 32-bit RAM (1-cycle read latency, byte enables, rvalid one cycle after req) between NUM_PORTS requesters, e.g. core instruction fetch, core data port and vector-unit memory port in the demo SoC.
- Grants at most one requester per cycle and forwards its request to the RAM.
- Records which port was granted and routes the returning rvalid/rdata back to that port only.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..8).
- ADDR_W, 32, address width passed through unchanged.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous, active-low reset.
- req_i  input  NUM_PORTS  per-port request.
- we_i  input  NUM_PORTS  per-port write enable.
- be_i  input  NUM_PORTS x 4  per-port byte enables.
- addr_i  input  NUM_PORTS x ADDR_W  per-port byte address.
- wdata_i  input  NUM_PORTS x 32  per-port write data.
- gnt_o  output  NUM_PORTS  per-port grant, combinational, one-hot or zero.
- rvalid_o  output  NUM_PORTS  per-port response valid.
- rdata_o  output  NUM_PORTS x 32  per-port read data; all ports receive ram_rdata_i.
- ram_req_o  output  1  request to RAM.
- ram_we_o  output  1  write enable to RAM.
- ram_be_o  output  4  byte enables to RAM.
- ram_addr_o  output  ADDR_W  address to RAM.
- ram_wdata_o  output  32  write data to RAM.
- ram_rvalid_i  input  1  RAM response valid.
- ram_rdata_i  input  32  RAM read data.

Behaviour:
- Request acceptance: a request is accepted in a cycle when req_i[p] && gnt_o[p]. A requester holds req, we, be, addr and wdata stable until granted.
- Grant: gnt_o is combinational from req_i and the arbitration state.
  - Exactly one bit is set when any req_i is set; gnt_o = 0 otherwise.
  - No grant is given to a port with req_i low.
- RAM forwarding:
  - ram_req_o = |req_i.
  - ram_we_o, ram_be_o, ram_addr_o and ram_wdata_o are muxed from the granted port.
  - When no port requests, these outputs are 0.
- Response tracking: registers resp_pend_q (1 bit) and resp_port_q ($clog2(NUM_PORTS) bits).
  - Each cycle: resp_pend_q <= ram_req_o; resp_port_q <= index of granted port when ram_req_o is high, otherwise unchanged.
  - rvalid_o[p] = ram_rvalid_i && resp_pend_q && (resp_port_q == p).
  - Writes also produce an rvalid (the RAM asserts rvalid for every req). Requesters ignore rdata on write responses.
- Latency: grant is in the request cycle; rvalid arrives 1 cycle later.
- Back-to-back: a new grant may be issued every cycle, including while a response is being returned. There is no bubble.
- Reset values: resp_pend_q = 0, resp_port_q = 0, last_q = NUM_PORTS-1. This makes port 0 win first under both policies.
- Reset mid-operation: any pending response is discarded and no rvalid_o is asserted in the first cycle after reset release.
- ram_rvalid_i without resp_pend_q: the response is dropped (rvalid_o = 0) and a simulation assertion fires.
- Arbitration policy without the optional feature: fixed priority, lowest index wins. last_q is still maintained but unused.

Optional Feature:
- Macro: RAM_ARBITER_RR_EN.
- When defined: round-robin arbitration.
  - The search starts at (last_q+1) mod NUM_PORTS and the first requesting port wins.
  - last_q <= granted index on each accepted request.
  - A continuously requesting port waits at most NUM_PORTS-1 cycles.
- When undefined: fixed priority as above. Port NUM_PORTS-1 may starve.

Decomposition:
- Package ram_arbiter_pkg:
  - typedef ram_req_t: struct with we, be[3:0], addr, wdata.
  - typedef ram_rsp_t: struct with rvalid, rdata.
  - Constant RAM_DATA_W = 32.
- One sub-module, ram_arbiter_pick: combinational priority picker.
  - Inputs: request vector, start index.
  - Outputs: one-hot grant, binary index.
  - Start index is tied to 0 for fixed priority and to last_q+1 for round-robin.

Test Plan:
- Single port read: port 1 requests addr 0x40 alone, RAM returns 0xDEADBEEF → gnt_o = 2'b10 the same cycle; next cycle rvalid_o = 2'b10 and rdata_o[1] = 0xDEADBEEF; rvalid_o[0] = 0.
- Simultaneous requests, fixed priority: ports 0 and 1 request every cycle for 4 cycles → gnt_o = 2'b01 in all 4 cycles; port 1 is never granted; 4 rvalids go to port 0.
- Simultaneous requests, RAM_ARBITER_RR_EN defined: same stimulus → grants alternate 01, 10, 01, 10; rvalids alternate identically one cycle later.
- Write then read: port 0 writes 0x11223344 with be = 4'b0101 to addr 0x8 over an initial 0xAAAAAAAA; port 1 then reads 0x8 → ram_be_o = 4'b0101 on the write; port 1 receives 0xAA22AA44.
- Reset mid-operation: grant port 1, assert rst_ni low in the next cycle before the response → after release rvalid_o = 0, resp_pend_q = 0; the next grant with both ports requesting goes to port 0.
- Idle: no requests for 10 cycles → ram_req_o = 0, gnt_o = 0, rvalid_o = 0; the spurious-rvalid assertion fires if ram_rvalid_i is forced high.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Request/response bundle types shared by the RAM arbiter and its picker.
package ram_arbiter_pkg;

  localparam int RAM_DATA_W     = 32;
  // Widest address any instance may carry; narrower ports use the low bits.
  localparam int RAM_ADDR_MAX_W = 64;

  typedef struct packed {
    logic                      we;
    logic [3:0]                be;
    logic [RAM_ADDR_MAX_W-1:0] addr;
    logic [RAM_DATA_W-1:0]     wdata;
  } ram_req_t;

  typedef struct packed {
    logic                  rvalid;
    logic [RAM_DATA_W-1:0] rdata;
  } ram_rsp_t;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational picker: first requesting port at or after start wins, wrapping.
// Zero latency; grant is one-hot or zero, no backpressure of its own.
module ram_arbiter_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(start) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between NUM_PORTS requesters; grant same cycle, rvalid one cycle later, no bubbles.
// Losing requesters simply hold their request; define RAM_ARBITER_RR_EN for round-robin instead of fixed priority.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][3:0]             be_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      addr_i,
  input  logic [NUM_PORTS-1:0][RAM_DATA_W-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [NUM_PORTS-1:0][RAM_DATA_W-1:0]  rdata_o,
  output logic                                  ram_req_o,
  output logic                                  ram_we_o,
  output logic [3:0]                            ram_be_o,
  output logic [ADDR_W-1:0]                     ram_addr_o,
  output logic [RAM_DATA_W-1:0]                 ram_wdata_o,
  input  logic                                  ram_rvalid_i,
  input  logic [RAM_DATA_W-1:0]                 ram_rdata_i
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  ram_req_t [NUM_PORTS-1:0] port_req;
  ram_req_t                 sel_req;
  ram_rsp_t                 ram_rsp;
  logic [IDX_W-1:0]         start_idx;
  logic [IDX_W-1:0]         gnt_idx;
  logic [IDX_W-1:0]         last_q;
  logic [IDX_W-1:0]         resp_port_q;
  logic                     resp_pend_q;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_req[p]                   = '0;
      port_req[p].we                = we_i[p];
      port_req[p].be                = be_i[p];
      port_req[p].addr[ADDR_W-1:0]  = addr_i[p];
      port_req[p].wdata             = wdata_i[p];
    end
  end

`ifdef RAM_ARBITER_RR_EN
  assign start_idx = (last_q == IDX_W'(NUM_PORTS - 1)) ? '0 : last_q + 1'b1;
`else
  // Fixed priority: search always starts at port 0; last_q is kept only for observability.
  logic unused_last;
  assign start_idx   = '0;
  assign unused_last = ^last_q;
`endif

  ram_arbiter_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_i),
    .start (start_idx),
    .gnt   (gnt_o),
    .idx   (gnt_idx)
  );

  // Idle cycles select nothing, so the RAM side sees all zeros.
  always_comb begin
    sel_req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_o[p]) sel_req = port_req[p];
    end
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_req.addr;

  assign ram_req_o   = |req_i;
  assign ram_we_o    = sel_req.we;
  assign ram_be_o    = sel_req.be;
  assign ram_addr_o  = sel_req.addr[ADDR_W-1:0];
  assign ram_wdata_o = sel_req.wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_pend_q <= 1'b0;
      resp_port_q <= '0;
      last_q      <= IDX_W'(NUM_PORTS - 1);
    end else begin
      resp_pend_q <= ram_req_o;
      if (ram_req_o) begin
        resp_port_q <= gnt_idx;
        last_q      <= gnt_idx;
      end
    end
  end

  assign ram_rsp = '{rvalid: ram_rvalid_i, rdata: ram_rdata_i};

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = ram_rsp.rvalid && resp_pend_q && (resp_port_q == IDX_W'(p));
      rdata_o[p]  = ram_rsp.rdata;
    end
  end

`ifndef SYNTHESIS
  spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i |-> resp_pend_q)
    else $error("ram_arbiter: ram_rvalid_i with no outstanding request");
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle RAM.
module tb_ram_arbiter;

  logic             clk;
  logic             rst_ni;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [1:0][31:0] rdata;
  logic             ram_req;
  logic             ram_we;
  logic [3:0]       ram_be;
  logic [31:0]      ram_addr;
  logic [31:0]      ram_wdata;
  logic             ram_rvalid;
  logic [31:0]      ram_rdata;

  int errors = 0;
  int checks = 0;

  ram_arbiter #(.NUM_PORTS(2), .ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req),
    .we_i         (we),
    .be_i         (be),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .ram_req_o    (ram_req),
    .ram_we_o     (ram_we),
    .ram_be_o     (ram_be),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_rvalid_i (ram_rvalid),
    .ram_rdata_i  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 32 words, word index from addr[6:2]; rvalid for every request.
  logic [31:0] mem [32];
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_rvalid <= 1'b0;
      ram_rdata  <= '0;
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[2]  <= 32'hAAAA_AAAA;
      mem[16] <= 32'hDEAD_BEEF;
    end else begin
      ram_rvalid <= ram_req;
      if (ram_req) begin
        ram_rdata <= mem[ram_addr[6:2]];
        if (ram_we) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_addr[6:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    cyc(); cyc();
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
    checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req: got %b want 0", ram_req); end
    checks++; if (dut.resp_pend_q !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", dut.resp_pend_q); end
    checks++; if (dut.resp_port_q !== 1'b0) begin errors++; $display("FAIL reset_port: got %b want 0", dut.resp_port_q); end
    checks++; if (dut.last_q !== 1'b1) begin errors++; $display("FAIL reset_last: got %b want 1", dut.last_q); end
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    cyc();
    req = 2'b10; addr[1] = 32'h40;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b want 10", gnt); end
    checks++; if (ram_req !== 1'b1) begin errors++; $display("FAIL single_ram_req: got %b want 1", ram_req); end
    checks++; if (ram_addr !== 32'h40) begin errors++; $display("FAIL single_addr: got %h want 00000040", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_we: got %b want 0", ram_we); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL single_rvalid: got %b want 10", rvalid); end
    checks++; if (rdata[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rdata[1]); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_idle: got %b want 00", gnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g [4];
    logic [31:0] exp_d;
`ifdef RAM_ARBITER_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_d = 32'h1000_0001;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
    exp_d = 32'h1000_0000;
`endif
    cyc();
    req = 2'b11; addr[0] = 32'h0; addr[1] = 32'h4;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, gnt, exp_g[k]); end
      checks++;
      if (rvalid !== ((k == 0) ? 2'b00 : exp_g[(k == 0) ? 0 : k-1])) begin
        errors++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, rvalid, (k == 0) ? 2'b00 : exp_g[(k == 0) ? 0 : k-1]);
      end
      cyc();
    end
    clear_inputs();
    #1;
    checks++; if (rvalid !== exp_g[3]) begin errors++; $display("FAIL b2b_rvalid_last: got %b want %b", rvalid, exp_g[3]); end
    checks++; if (ram_rdata !== exp_d) begin errors++; $display("FAIL b2b_rdata_last: got %h want %h", ram_rdata, exp_d); end
  endtask

  task automatic test_write_read();
    cyc();
    req = 2'b01; we = 2'b01; be[0] = 4'b0101; addr[0] = 32'h8; wdata[0] = 32'h1122_3344;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", gnt); end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", ram_we); end
    checks++; if (ram_be !== 4'b0101) begin errors++; $display("FAIL wr_be: got %b want 0101", ram_be); end
    checks++; if (ram_wdata !== 32'h1122_3344) begin errors++; $display("FAIL wr_wdata: got %h want 11223344", ram_wdata); end
    cyc();
    clear_inputs();
    req = 2'b10; addr[1] = 32'h8;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b want 10", gnt); end
    checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL wr_rvalid: got %b want 01", rvalid); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", ram_we); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b want 10", rvalid); end
    checks++; if (rdata[1] !== 32'hAA22_AA44) begin errors++; $display("FAIL rd_rdata: got %h want aa22aa44", rdata[1]); end
  endtask

  task automatic test_reset_mid();
    cyc();
    req = 2'b10; addr[1] = 32'h40;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rmid_gnt: got %b want 10", gnt); end
    cyc();
    rst_ni = 1'b0;
    clear_inputs();
    #1;
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rmid_rvalid_in_reset: got %b want 00", rvalid); end
    cyc(); cyc();
    rst_ni = 1'b1;
    #1;
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rmid_rvalid_after: got %b want 00", rvalid); end
    checks++; if (dut.resp_pend_q !== 1'b0) begin errors++; $display("FAIL rmid_pend: got %b want 0", dut.resp_pend_q); end
    req = 2'b11; addr[0] = 32'h0; addr[1] = 32'h4;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmid_first_gnt: got %b want 01", gnt); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL rmid_rvalid: got %b want 01", rvalid); end
    checks++; if (rdata[0] !== 32'h1000_0000) begin errors++; $display("FAIL rmid_rdata: got %h want 10000000", rdata[0]); end
  endtask

  task automatic test_idle();
    cyc(); cyc();
    // Non-zero payload on idle ports must not leak to the RAM side.
    req = '0; we = 2'b11; be[0] = 4'hF; be[1] = 4'hF;
    addr[0] = 32'h1234; addr[1] = 32'h5678; wdata[0] = 32'hCAFE_0000; wdata[1] = 32'h0000_F00D;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL idle_ram_req[%0d]: got %b want 0", k, ram_req); end
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL idle_gnt[%0d]: got %b want 00", k, gnt); end
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL idle_rvalid[%0d]: got %b want 00", k, rvalid); end
      checks++;
      if ({ram_we, ram_be, ram_addr, ram_wdata} !== '0) begin
        errors++; $display("FAIL idle_ram_bus[%0d]: got we=%b be=%b addr=%h wdata=%h want all 0", k, ram_we, ram_be, ram_addr, ram_wdata);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_read();
    test_reset_mid();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
